// File: rtl/regfile_writeback.sv
// Writeback stage for the 32x32 integer register file write port.
// Merges single-cycle ALU results with load results, queuing loads that
// collide with ALU writes, and issues at most one write per cycle.
// Optional feature macro: REGFILE_WB_FWD_EN enables the forwarding outputs;
// when undefined the forwarding ports are tied to zero.
module regfile_writeback #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        lsu_valid,
  output logic        lsu_ready,
  input  logic [4:0]  lsu_rd,
  input  logic [31:0] lsu_data,
  output logic        we3,
  output logic [4:0]  a3,
  output logic [31:0] wd3,
  output logic        busy,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  output logic        fwd1_hit,
  output logic        fwd2_hit,
  output logic [31:0] fwd1_data,
  output logic [31:0] fwd2_data
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  // Queue storage: rd/data need no reset, the valid bits gate everything.
  logic [4:0]       r_q_rd   [DEPTH];
  logic [31:0]      r_q_data [DEPTH];
  logic [DEPTH-1:0] r_q_vld;
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [PW:0]      r_count;

  logic        r_we3;
  logic [4:0]  r_a3;
  logic [31:0] r_wd3;

  logic             w_empty;
  logic             w_hs;
  logic             w_alu_sel;
  logic             w_pop;
  logic             w_direct;
  logic             w_push;
  logic             w_push_vld;
  logic             w_head_vld;
  logic [4:0]       w_head_rd;
  logic [31:0]      w_head_data;
  logic             w_we_next;
  logic [4:0]       w_a3_next;
  logic [31:0]      w_wd3_next;
  logic [DEPTH-1:0] w_vld_next;

  assign w_empty     = (r_count == '0);
  assign lsu_ready   = (r_count != FULL_CNT);
  assign w_hs        = lsu_valid && lsu_ready;
  assign w_alu_sel   = alu_valid && (alu_rd != 5'd0);
  assign w_pop       = !w_alu_sel && !w_empty;
  assign w_direct    = !w_alu_sel && w_empty && w_hs && (lsu_rd != 5'd0);
  assign w_push      = w_hs && (lsu_rd != 5'd0) && !w_direct;
  // A load pushed in the same cycle as an ALU write to the same rd is
  // already stale: the ALU result is architecturally younger.
  assign w_push_vld  = !(w_alu_sel && (alu_rd == lsu_rd));
  assign w_head_vld  = r_q_vld[r_rd_ptr];
  assign w_head_rd   = r_q_rd[r_rd_ptr];
  assign w_head_data = r_q_data[r_rd_ptr];

  // Per-entry valid next state: fill on push, drop on pop or WAW kill.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_vld
      assign w_vld_next[gi] =
        (w_push && (r_wr_ptr == PW'(gi))) ? w_push_vld :
        (w_pop  && (r_rd_ptr == PW'(gi))) ? 1'b0 :
        (w_alu_sel && (r_q_rd[gi] == alu_rd)) ? 1'b0 : r_q_vld[gi];
    end
  endgenerate

  // Write selection: ALU, then queue head, then direct LSU.
  always_comb begin
    w_we_next  = 1'b0;
    w_a3_next  = r_a3;
    w_wd3_next = r_wd3;
    if (w_alu_sel) begin
      w_we_next  = 1'b1;
      w_a3_next  = alu_rd;
      w_wd3_next = alu_data;
    end else if (w_pop) begin
      w_we_next = w_head_vld;
      if (w_head_vld) begin
        w_a3_next  = w_head_rd;
        w_wd3_next = w_head_data;
      end
    end else if (w_direct) begin
      w_we_next  = 1'b1;
      w_a3_next  = lsu_rd;
      w_wd3_next = lsu_data;
    end
  end

  // Queue payload write at the tail.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_rd[r_wr_ptr]   <= lsu_rd;
      r_q_data[r_wr_ptr] <= lsu_data;
    end
  end

  // Queue control state: pointers, count and valid bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_q_vld  <= '0;
    end else begin
      r_q_vld <= w_vld_next;
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= r_count + {{PW{1'b0}}, w_push} - {{PW{1'b0}}, w_pop};
    end
  end

  // Registered register-file write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we3 <= 1'b0;
      r_a3  <= '0;
      r_wd3 <= '0;
    end else begin
      r_we3 <= w_we_next;
      r_a3  <= w_a3_next;
      r_wd3 <= w_wd3_next;
    end
  end

  assign we3  = r_we3;
  assign a3   = r_a3;
  assign wd3  = r_wd3;
  assign busy = !w_empty || r_we3;

`ifdef REGFILE_WB_FWD_EN
  assign fwd1_hit  = r_we3 && (r_a3 == rs1) && (rs1 != 5'd0);
  assign fwd2_hit  = r_we3 && (r_a3 == rs2) && (rs2 != 5'd0);
  assign fwd1_data = fwd1_hit ? r_wd3 : 32'd0;
  assign fwd2_data = fwd2_hit ? r_wd3 : 32'd0;
`else
  logic w_unused_rs;
  assign w_unused_rs = ^{rs1, rs2};
  assign fwd1_hit  = 1'b0;
  assign fwd2_hit  = 1'b0;
  assign fwd1_data = 32'd0;
  assign fwd2_data = 32'd0;
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// Bench for regfile_writeback: directed steps plus randomized traffic,
// checked against a queue-based reference model of the writeback rules.
module tb_regfile_writeback;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        we3;
  logic [4:0]  a3;
  logic [31:0] wd3;
  logic        busy;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        fwd1_hit;
  logic        fwd2_hit;
  logic [31:0] fwd1_data;
  logic [31:0] fwd2_data;

  regfile_writeback #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .we3(we3), .a3(a3), .wd3(wd3), .busy(busy),
    .rs1(rs1), .rs2(rs2),
    .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit),
    .fwd1_data(fwd1_data), .fwd2_data(fwd2_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    bit          vld;
  } ent_t;

  ent_t        mq[$];
  bit          exp_we;
  logic [4:0]  exp_a3;
  logic [31:0] exp_wd;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
  endtask

  // One clock: check ready, advance model, check registered outputs.
  task automatic cycle(input string tag);
    bit          ready_m;
    bit          hs;
    bit          direct;
    bit          h1, h2;
    ent_t        e;
    logic [31:0] d1, d2;
    ready_m = (mq.size() < DEPTH);
    chk({tag, ":ready"}, 32'(lsu_ready), 32'(ready_m));
    hs     = lsu_valid && ready_m;
    direct = 1'b0;
    exp_we = 1'b0;
    if (alu_valid && alu_rd != 5'd0) begin
      exp_we = 1'b1; exp_a3 = alu_rd; exp_wd = alu_data;
      foreach (mq[i]) if (mq[i].rd == alu_rd) mq[i].vld = 1'b0;
    end else if (mq.size() > 0) begin
      e = mq.pop_front();
      if (e.vld) begin
        exp_we = 1'b1; exp_a3 = e.rd; exp_wd = e.data;
      end
    end else if (hs && lsu_rd != 5'd0) begin
      direct = 1'b1;
      exp_we = 1'b1; exp_a3 = lsu_rd; exp_wd = lsu_data;
    end
    if (hs && lsu_rd != 5'd0 && !direct) begin
      e.rd = lsu_rd; e.data = lsu_data;
      e.vld = !(alu_valid && alu_rd == lsu_rd);
      mq.push_back(e);
    end
    @(posedge clk);
    #1;
    chk({tag, ":we3"}, 32'(we3), 32'(exp_we));
    if (exp_we) begin
      chk({tag, ":a3"}, 32'(a3), 32'(exp_a3));
      chk({tag, ":wd3"}, wd3, exp_wd);
    end
    chk({tag, ":busy"}, 32'(busy), 32'(mq.size() > 0 || exp_we));
`ifdef REGFILE_WB_FWD_EN
    h1 = exp_we && exp_a3 == rs1 && rs1 != 5'd0;
    h2 = exp_we && exp_a3 == rs2 && rs2 != 5'd0;
`else
    h1 = 1'b0;
    h2 = 1'b0;
`endif
    d1 = h1 ? exp_wd : 32'd0;
    d2 = h2 ? exp_wd : 32'd0;
    chk({tag, ":fwd1_hit"}, 32'(fwd1_hit), 32'(h1));
    chk({tag, ":fwd2_hit"}, 32'(fwd2_hit), 32'(h2));
    chk({tag, ":fwd1_data"}, fwd1_data, d1);
    chk({tag, ":fwd2_data"}, fwd2_data, d2);
    $display("cycle %s we3=%0d a3=%0d wd3=%h q=%0d", tag, we3, a3, wd3, mq.size());
    @(negedge clk);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, ":we3"}, 32'(we3), 32'd0);
    chk({tag, ":a3"}, 32'(a3), 32'd0);
    chk({tag, ":wd3"}, wd3, 32'd0);
    chk({tag, ":busy"}, 32'(busy), 32'd0);
    chk({tag, ":ready"}, 32'(lsu_ready), 32'd1);
  endtask

  initial begin
    int lsu_idx;
    int guard;
    rst_n = 1'b0;
    rs1 = '0; rs2 = '0;
    idle_inputs();
    exp_we = 1'b0; exp_a3 = '0; exp_wd = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_state("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Single ALU write, then nothing.
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    cycle("alu5");
    idle_inputs();
    cycle("alu5_after");

    // Writes to x0 from either source are dropped.
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h1234;
    cycle("alu_x0");
    idle_inputs();
    lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 32'h5678;
    cycle("lsu_x0");
    idle_inputs();
    cycle("x0_after");

    // ALU stream fills the queue; loads drain in order afterwards.
    lsu_idx = 0;
    for (int i = 0; i < 5; i++) begin
      alu_valid = 1'b1; alu_rd = 5'(i + 1); alu_data = 32'h100 + 32'(i);
      lsu_valid = 1'b1; lsu_rd = 5'(10 + lsu_idx); lsu_data = 32'hA00 + 32'(lsu_idx);
      guard = int'(lsu_ready);
      cycle("fill");
      lsu_idx += guard;
    end
    chk("fill:accepted", 32'(lsu_idx), 32'd4);
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    for (int i = 0; i < 8; i++) begin
      lsu_valid = (lsu_idx < 5);
      lsu_rd = 5'(10 + lsu_idx); lsu_data = 32'hA00 + 32'(lsu_idx);
      guard = int'(lsu_valid && lsu_ready);
      cycle("drain");
      lsu_idx += guard;
    end
    chk("drain:accepted", 32'(lsu_idx), 32'd5);
    idle_inputs();

    // WAW: queued load to rd 7 is killed by a younger ALU write.
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h11;
    lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'hAAAA0000;
    cycle("waw_push");
    idle_inputs();
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h55;
    cycle("waw_alu");
    idle_inputs();
    cycle("waw_pop");
    cycle("waw_idle");

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      alu_valid = ($urandom_range(0, 99) < 40);
      alu_rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      alu_data  = $urandom;
      lsu_valid = ($urandom_range(0, 99) < 60);
      lsu_rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) lsu_rd = alu_rd;
      lsu_data  = $urandom;
      rs1 = ($urandom_range(0, 1) == 1) ? exp_a3 : 5'($urandom_range(0, 31));
      rs2 = 5'($urandom_range(0, 31));
      cycle("rand");
    end
    idle_inputs();
    rs1 = '0; rs2 = '0;
    guard = 0;
    while (busy && guard < 20) begin
      cycle("settle");
      guard++;
    end
    chk("settle:empty", 32'(mq.size()), 32'd0);

    // Reset mid-operation with three queued loads.
    for (int i = 0; i < 3; i++) begin
      alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h300 + 32'(i);
      lsu_valid = 1'b1; lsu_rd = 5'(20 + i); lsu_data = 32'hB00 + 32'(i);
      cycle("prerst");
    end
    idle_inputs();
    rst_n = 1'b0;
    #1;
    chk_reset_state("midrst");
    mq.delete();
    exp_we = 1'b0; exp_a3 = '0; exp_wd = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) cycle("postrst");

    // Forwarding from the registered stage.
    alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h42;
    rs1 = 5'd9; rs2 = 5'd0;
    cycle("fwd");
    idle_inputs();
    rs1 = 5'd9; rs2 = 5'd9;
    alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h77;
    cycle("fwd_both");
    idle_inputs();
    cycle("fwd_idle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
